// File: rtl/coherency_ctrl_pkg.sv
// Shared types and constants for the coherency controller's watch engine.
// Sizes, address/backoff types and the poll scheduler's FSM encoding live here.
package coherency_ctrl_pkg;

  localparam int unsigned CACHE_LINE_NUM = 4;
  localparam int unsigned BACKOFF_WIDTH  = 16;
  localparam int unsigned ADDR_WIDTH     = 64;
  localparam int unsigned LINE_BYTES     = 64;
  localparam int unsigned DATA_WIDTH     = 64;
  localparam int unsigned SIZE_WIDTH     = $clog2(CACHE_LINE_NUM) + 1;
  localparam int unsigned IDX_WIDTH      = $clog2(CACHE_LINE_NUM);

  typedef logic [ADDR_WIDTH-1:0]     addr_t;
  typedef logic [SIZE_WIDTH-1:0]     size_t;
  typedef logic [BACKOFF_WIDTH-1:0]  backoff_t;
  typedef logic [CACHE_LINE_NUM-1:0] line_mask_t;
  typedef logic [DATA_WIDTH-1:0]     data_word_t;
  typedef logic [IDX_WIDTH-1:0]      idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME_REQ,
    S_PRIME_WAIT,
    S_BACKOFF,
    S_POLL_REQ,
    S_POLL_WAIT,
    S_EVENT
  } sched_state_e;

  function automatic backoff_t backoff_min(input backoff_t a, input backoff_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/coherency_backoff_ctr.sv
// Current backoff value (reload / saturating double) and the inter-sweep countdown.
// start loads the countdown with the backoff value being written in the same cycle.
module coherency_backoff_ctr
  import coherency_ctrl_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     load_init,
  input  logic     double,
  input  logic     start,
  input  backoff_t init,
  input  backoff_t max,
  output logic     done,
  output backoff_t cur
);

  backoff_t cur_q, cur_d;
  backoff_t cnt_q, cnt_d;
  logic [BACKOFF_WIDTH:0] dbl;

  always_comb begin
    dbl   = {cur_q, 1'b0};
    cur_d = cur_q;
    if (load_init) begin
      cur_d = backoff_min(init, max);
    end else if (double) begin
      if (cur_q == '0) begin
        cur_d = backoff_t'(1);
      end else if (dbl > {1'b0, max}) begin
        cur_d = max;
      end else begin
        cur_d = dbl[BACKOFF_WIDTH-1:0];
      end
    end

    cnt_d = cnt_q;
    if (start) begin
      cnt_d = cur_d;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - backoff_t'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_q <= '0;
      cnt_q <= '0;
    end else begin
      cur_q <= cur_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);
  assign cur  = cur_q;

endmodule

// File: rtl/coherency_poll_sched.sv
// Watch-engine sequencer: primes per-line snapshots, then polls them one request
// at a time, raising a changed-line event and backing off exponentially between sweeps.
module coherency_poll_sched
  import coherency_ctrl_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  addr_t                     cfg_base_i,
  input  size_t                     cfg_size_i,
  input  backoff_t                  cfg_backoff_init_i,
  input  backoff_t                  cfg_backoff_max_i,
  input  logic                      stop_i,
  output logic                      req_valid_o,
  input  logic                      req_ready_i,
  output addr_t                     req_addr_o,
  input  logic                      resp_valid_i,
  input  logic [DATA_WIDTH-1:0]     resp_data_i,
  output logic                      evt_valid_o,
  input  logic                      evt_ready_i,
  output logic [CACHE_LINE_NUM-1:0] evt_mask_o,
  output logic                      busy_o
);

  localparam size_t MAX_SIZE = size_t'(CACHE_LINE_NUM);

  sched_state_e state_q, state_d;
  idx_t         idx_q, idx_d;
  size_t        size_q, size_d;
  addr_t        base_q, base_d;
  backoff_t     init_q, init_d;
  backoff_t     max_q, max_d;
  line_mask_t   mask_q, mask_d;
  data_word_t   snap_q [CACHE_LINE_NUM];
  data_word_t   snap_d [CACHE_LINE_NUM];
  logic         stop_pend_q, stop_pend_d;

  logic       cfg_fire, last_line, line_chg, sweep_end;
  logic       bo_load_init, bo_double, bo_start, bo_done;
  size_t      size_clamped;
  line_mask_t mask_final;
  backoff_t   bo_init, bo_max, bo_cur;

  // mask_final folds the response being accepted into the sweep mask, so the
  // last line's change decides event-vs-backoff in the same cycle.
  always_comb begin
    cfg_fire     = cfg_valid_i && (state_q == S_IDLE);
    size_clamped = (cfg_size_i > MAX_SIZE) ? MAX_SIZE : cfg_size_i;
    last_line    = (size_t'(idx_q) + size_t'(1)) == size_q;
    line_chg     = resp_data_i != snap_q[idx_q];
    mask_final   = mask_q | (line_mask_t'(line_chg) << idx_q);
    sweep_end    = (state_q == S_POLL_WAIT) && resp_valid_i && last_line;
    bo_load_init = (cfg_fire && (size_clamped != '0)) || (sweep_end && (mask_final != '0));
    bo_double    = sweep_end && (mask_final == '0);
    bo_start     = ((state_q == S_PRIME_WAIT) && resp_valid_i && last_line)
                || bo_double
                || ((state_q == S_EVENT) && evt_ready_i);
    bo_init      = cfg_fire ? cfg_backoff_init_i : init_q;
    bo_max       = cfg_fire ? cfg_backoff_max_i  : max_q;
  end

  coherency_backoff_ctr u_backoff (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_init (bo_load_init),
    .double    (bo_double),
    .start     (bo_start),
    .init      (bo_init),
    .max       (bo_max),
    .done      (bo_done),
    .cur       (bo_cur)
  );

  // Doubling from zero yields one even under a zero cap; otherwise the cap holds.
  assert property (@(posedge clk_i) disable iff (rst_i)
                   (bo_cur <= max_q) || (bo_cur == backoff_t'(1)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (cfg_fire && (size_clamped != '0)) state_d = S_PRIME_REQ;
      S_PRIME_REQ:  if (req_ready_i) state_d = S_PRIME_WAIT;
      S_PRIME_WAIT: if (resp_valid_i) state_d = last_line ? S_BACKOFF : S_PRIME_REQ;
      S_BACKOFF: begin
        if (stop_pend_q) begin
          state_d = S_IDLE;
        end else if (bo_done) begin
          state_d = S_POLL_REQ;
        end
      end
      S_POLL_REQ:   if (req_ready_i) state_d = S_POLL_WAIT;
      S_POLL_WAIT: begin
        if (resp_valid_i) begin
          if (!last_line) begin
            state_d = S_POLL_REQ;
          end else begin
            state_d = (mask_final != '0) ? S_EVENT : S_BACKOFF;
          end
        end
      end
      S_EVENT:      if (evt_ready_i) state_d = S_BACKOFF;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_o = (state_q == S_IDLE);
    busy_o      = (state_q != S_IDLE);
    req_valid_o = (state_q == S_PRIME_REQ) || (state_q == S_POLL_REQ);
    req_addr_o  = '0;
    if (req_valid_o) begin
      req_addr_o = base_q + addr_t'(idx_q) * addr_t'(LINE_BYTES);
    end
    evt_valid_o = (state_q == S_EVENT);
    evt_mask_o  = evt_valid_o ? mask_q : '0;
  end

  always_comb begin
    idx_d       = idx_q;
    size_d      = size_q;
    base_d      = base_q;
    init_d      = init_q;
    max_d       = max_q;
    mask_d      = mask_q;
    snap_d      = snap_q;
    stop_pend_d = stop_pend_q;

    if ((state_q != S_IDLE) && stop_i) begin
      stop_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_fire) begin
          base_d      = cfg_base_i;
          size_d      = size_clamped;
          init_d      = cfg_backoff_init_i;
          max_d       = cfg_backoff_max_i;
          idx_d       = '0;
          mask_d      = '0;
          stop_pend_d = 1'b0;
        end
      end
      S_PRIME_WAIT: begin
        if (resp_valid_i) begin
          snap_d[idx_q] = resp_data_i;
          idx_d         = last_line ? '0 : idx_q + idx_t'(1);
        end
      end
      S_POLL_WAIT: begin
        if (resp_valid_i) begin
          if (line_chg) begin
            snap_d[idx_q] = resp_data_i;
          end
          mask_d = mask_final;
          idx_d  = last_line ? '0 : idx_q + idx_t'(1);
        end
      end
      S_BACKOFF: begin
        if (stop_pend_q) begin
          stop_pend_d = 1'b0;
        end else if (bo_done) begin
          idx_d  = '0;
          mask_d = '0;
        end
      end
      S_EVENT: begin
        if (evt_ready_i) begin
          mask_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q       <= '0;
      size_q      <= '0;
      base_q      <= '0;
      init_q      <= '0;
      max_q       <= '0;
      mask_q      <= '0;
      snap_q      <= '{default: '0};
      stop_pend_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      size_q      <= size_d;
      base_q      <= base_d;
      init_q      <= init_d;
      max_q       <= max_d;
      mask_q      <= mask_d;
      snap_q      <= snap_d;
      stop_pend_q <= stop_pend_d;
    end
  end

endmodule

// File: tb/tb_coherency_poll_sched.sv
// Scoreboard bench for coherency_poll_sched: a sweep-level model queues expected
// requests, backoff gaps and events; a monitor checks them as the DUT presents them.
`timescale 1ns/1ps
module tb_coherency_poll_sched;
  import coherency_ctrl_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cfg_valid_i, cfg_ready_o;
  addr_t      cfg_base_i;
  size_t      cfg_size_i;
  backoff_t   cfg_backoff_init_i, cfg_backoff_max_i;
  logic       stop_i;
  logic       req_valid_o, req_ready_i;
  addr_t      req_addr_o;
  logic       resp_valid_i;
  data_word_t resp_data_i;
  logic       evt_valid_o, evt_ready_i;
  line_mask_t evt_mask_o;
  logic       busy_o;

  coherency_poll_sched dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .cfg_valid_i        (cfg_valid_i),
    .cfg_ready_o        (cfg_ready_o),
    .cfg_base_i         (cfg_base_i),
    .cfg_size_i         (cfg_size_i),
    .cfg_backoff_init_i (cfg_backoff_init_i),
    .cfg_backoff_max_i  (cfg_backoff_max_i),
    .stop_i             (stop_i),
    .req_valid_o        (req_valid_o),
    .req_ready_i        (req_ready_i),
    .req_addr_o         (req_addr_o),
    .resp_valid_i       (resp_valid_i),
    .resp_data_i        (resp_data_i),
    .evt_valid_o        (evt_valid_o),
    .evt_ready_i        (evt_ready_i),
    .evt_mask_o         (evt_mask_o),
    .busy_o             (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef enum int {K_REQ, K_WAIT, K_EVT, K_IDLE} kind_e;
  typedef struct { kind_e k; logic [63:0] v; } exp_t;
  typedef struct { data_word_t d; bit stop; } rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   hold_ready = 1'b0;
  int   evt_hold = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endfunction

  function automatic void push_exp(input kind_e k, input logic [63:0] v);
    exp_t e;
    e.k = k;
    e.v = v;
    exp_q.push_back(e);
  endfunction

  function automatic void push_rsp(input data_word_t d, input bit stop);
    rsp_t r;
    r.d    = d;
    r.stop = stop;
    rsp_q.push_back(r);
  endfunction

  function automatic data_word_t rand_word();
    return {$urandom(), $urandom()};
  endfunction

  // Monitor: a backoff cycle is any busy cycle with no request, no event and no read in flight.
  initial begin : monitor
    bit   outst;
    int   run;
    exp_t e;
    outst = 1'b0;
    run   = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        outst = 1'b0;
        run   = 0;
      end else begin
        if (busy_o && !req_valid_o && !evt_valid_o && !outst) begin
          run++;
        end else if (run > 0) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_backoff_end");
          end else begin
            e = exp_q.pop_front();
            if (!busy_o) begin
              check("idle_kind", 64'(e.k), 64'(K_IDLE));
              check("backoff_before_idle", 64'(run), e.v);
              check("cfg_ready_after_stop", 64'(cfg_ready_o), 64'd1);
            end else begin
              check("wait_kind", 64'(e.k), 64'(K_WAIT));
              check("backoff_cycles", 64'(run), e.v);
            end
          end
          run = 0;
        end
        if (resp_valid_i) outst = 1'b0;
        if (req_valid_o && req_ready_i) begin
          outst = 1'b1;
          if (exp_q.size() == 0) begin
            fail_now("unexpected_request");
          end else begin
            e = exp_q.pop_front();
            check("req_kind", 64'(e.k), 64'(K_REQ));
            check("req_addr", req_addr_o, e.v);
          end
        end
        if (evt_valid_o) begin
          if (exp_q.size() == 0 || exp_q[0].k != K_EVT) begin
            fail_now("unexpected_event");
            if (evt_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
          end else begin
            check("evt_mask", 64'(evt_mask_o), exp_q[0].v);
            if (evt_ready_i) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Memory side: random ready, 0..2 cycle response latency, data and stop pulses from rsp_q.
  initial begin : responder
    bit   hs;
    int   lat;
    rsp_t r;
    lat = -1;
    forever begin
      @(negedge clk_i);
      hs = req_valid_o && req_ready_i && !rst_i;
      @(posedge clk_i);
      #1;
      resp_valid_i = 1'b0;
      stop_i       = 1'b0;
      req_ready_i  = !hold_ready && ($urandom_range(0, 3) != 0);
      if (hs) lat = $urandom_range(0, 2);
      if (lat == 0) begin
        if (rsp_q.size() == 0) begin
          fail_now("no_response_data");
        end else begin
          r            = rsp_q.pop_front();
          resp_valid_i = 1'b1;
          resp_data_i  = r.d;
          stop_i       = r.stop;
        end
        lat = -1;
      end else if (lat > 0) begin
        lat--;
      end
    end
  end

  initial begin : evt_sink
    int ewait;
    ewait = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (evt_valid_o) begin
        if (ewait >= evt_hold) begin
          evt_ready_i = 1'b1;
        end else begin
          evt_ready_i = 1'b0;
          ewait++;
        end
      end else begin
        evt_ready_i = 1'b0;
        ewait       = 0;
      end
    end
  end

  task automatic drive_cfg(input addr_t base, input int csz, input int init, input int bmax);
    @(posedge clk_i);
    #2;
    check("cfg_ready_before_cfg", 64'(cfg_ready_o), 64'd1);
    cfg_valid_i        = 1'b1;
    cfg_base_i         = base;
    cfg_size_i         = size_t'(csz);
    cfg_backoff_init_i = backoff_t'(init);
    cfg_backoff_max_i  = backoff_t'(bmax);
    @(posedge clk_i);
    #2;
    cfg_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while (!(exp_q.size() == 0 && !busy_o) && c < 20000) begin
      @(negedge clk_i);
      c++;
    end
    if (c >= 20000) begin
      $display("FAIL %s_timeout: %0d expectations left", name, exp_q.size());
      errors++;
      checks++;
      exp_q.delete();
      rsp_q.delete();
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
    end
    check("responses_consumed", 64'(rsp_q.size()), 64'd0);
  endtask

  // Sweep-level model: directed mode primes 0xA everywhere and changes line 2 to 0xB in sweep 0.
  task automatic run_batch(input string name, input addr_t base, input int csz, input int init,
                           input int bmax, input int nsw, input int pct, input bit directed,
                           input int stop_line);
    int         sz, cur, sl, mask;
    bit         last;
    data_word_t d;
    data_word_t snap [CACHE_LINE_NUM];
    sz = (csz > int'(CACHE_LINE_NUM)) ? int'(CACHE_LINE_NUM) : csz;
    sl = (stop_line < sz) ? stop_line : sz - 1;
    for (int i = 0; i < sz; i++) begin
      d       = directed ? 64'hA : rand_word();
      snap[i] = d;
      push_exp(K_REQ, base + addr_t'(i * int'(LINE_BYTES)));
      push_rsp(d, 1'b0);
    end
    cur = (init < bmax) ? init : bmax;
    if (sz > 0) push_exp(K_WAIT, 64'(cur + 1));
    for (int s = 0; s < nsw && sz > 0; s++) begin
      mask = 0;
      last = (s == nsw - 1);
      for (int i = 0; i < sz; i++) begin
        if (directed) d = (s == 0 && i == 2) ? 64'hB : snap[i];
        else          d = ($urandom_range(0, 99) < pct) ? rand_word() : snap[i];
        push_exp(K_REQ, base + addr_t'(i * int'(LINE_BYTES)));
        push_rsp(d, last && (i == sl));
        if (d != snap[i]) begin
          mask    = mask | (1 << i);
          snap[i] = d;
        end
      end
      if (mask != 0) begin
        push_exp(K_EVT, 64'(mask));
        cur = (init < bmax) ? init : bmax;
      end else begin
        cur = (cur == 0) ? 1 : ((2 * cur < bmax) ? 2 * cur : bmax);
      end
      if (last) push_exp(K_IDLE, 64'd1);
      else      push_exp(K_WAIT, 64'(cur + 1));
    end
    drive_cfg(base, csz, init, bmax);
    drain(name);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int c;
    rst_i              = 1'b1;
    cfg_valid_i        = 1'b0;
    cfg_base_i         = '0;
    cfg_size_i         = '0;
    cfg_backoff_init_i = '0;
    cfg_backoff_max_i  = '0;
    stop_i             = 1'b0;
    req_ready_i        = 1'b0;
    resp_valid_i       = 1'b0;
    resp_data_i        = '0;
    evt_ready_i        = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_cfg_ready", 64'(cfg_ready_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_req_valid", 64'(req_valid_o), 64'd0);
    check("rst_req_addr", req_addr_o, 64'd0);
    check("rst_evt_valid", 64'(evt_valid_o), 64'd0);
    check("rst_evt_mask", 64'(evt_mask_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    run_batch("priming", 64'h1000, 3, 2, 16, 1, 0, 1'b0, 1);
    run_batch("growth", 64'h2000, 2, 1, 8, 6, 0, 1'b0, 1);
    evt_hold = 5;
    run_batch("event", 64'h3000, 4, 1, 8, 2, 0, 1'b1, 1);
    run_batch("stop_evt", 64'h5000, 4, 3, 8, 1, 0, 1'b1, 1);
    evt_hold = 1;
    run_batch("clamp", 64'h4000, 7, 0, 4, 3, 40, 1'b0, 1);
    run_batch("wrap", 64'hFFFF_FFFF_FFFF_FF80, 4, 0, 2, 3, 50, 1'b0, 2);

    drive_cfg(64'h6000, 0, 3, 3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check("size0_busy", 64'(busy_o), 64'd0);
      check("size0_req_valid", 64'(req_valid_o), 64'd0);
    end

    for (int b = 0; b < 6; b++) begin
      evt_hold = $urandom_range(0, 3);
      run_batch("random", {$urandom(), $urandom()}, $urandom_range(1, 7),
                $urandom_range(0, 5), $urandom_range(0, 10), $urandom_range(2, 5),
                $urandom_range(10, 60), 1'b0, $urandom_range(0, 3));
    end

    // Reset while a poll request is waiting for ready.
    push_exp(K_REQ, 64'h7000);
    push_exp(K_REQ, 64'h7040);
    push_rsp(64'h11, 1'b0);
    push_rsp(64'h22, 1'b0);
    push_exp(K_WAIT, 64'd4);
    drive_cfg(64'h7000, 2, 3, 16);
    c = 0;
    while (exp_q.size() > 1 && c < 2000) begin
      @(negedge clk_i);
      c++;
    end
    hold_ready = 1'b1;
    while (exp_q.size() > 0 && c < 2000) begin
      @(negedge clk_i);
      c++;
    end
    if (c >= 2000) fail_now("reset_setup_timeout");
    check("pre_reset_req_valid", 64'(req_valid_o), 64'd1);
    check("pre_reset_addr", req_addr_o, 64'h7000);
    #2;
    rst_i = 1'b1;
    #1;
    check("reset_req_valid_drop", 64'(req_valid_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    rst_i      = 1'b0;
    hold_ready = 1'b0;
    repeat (2) @(negedge clk_i);
    check("post_reset_cfg_ready", 64'(cfg_ready_o), 64'd1);
    check("post_reset_busy", 64'(busy_o), 64'd0);
    exp_q.delete();
    rsp_q.delete();

    evt_hold = 2;
    run_batch("after_reset", 64'h8000, 3, 1, 6, 3, 50, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
